uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver: 8N1, LSB first, idle-high line.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 37 +++
 rtl/uart_sync.sv | 32 +++
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions, used by both the receive and transmit sides.
//   - DATA_BITS       : payload width of one serial frame
//   - uart_rx_state_t : receiver FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Bundle between the RX pin, the receiver and the byte consumer.
//   - i_serial    : raw asynchronous serial line, idle high
//   - o_data      : last good byte, held until the next good byte
//   - o_valid     : 1-cycle pulse, o_data holds a new good byte
//   - o_frame_err : 1-cycle pulse, stop bit was sampled low
//   - o_busy      : receiver is inside a frame (state != IDLE)
//   Modports: master = the receiver, slave = pin driver / byte consumer.
// -----------------------------------------------------------------------------
import uart_pkg::*;

interface uart_rx_if;

    logic                 i_serial;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_frame_err;
    logic                 o_busy;

    modport master (
        input  i_serial,
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_busy
    );

    modport slave (
        output i_serial,
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_busy
    );

endinterface : uart_rx_if

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
//   Two-flop synchronizer for a single asynchronous input.
//   - clock     : destination clock
//   - reset     : synchronous, active-high; both flops load RESET_VAL
//   - d         : asynchronous input
//   - q         : synchronized output
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its source; '=' here would collapse the two stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : uart_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver, LSB first, idle-high line. Each good byte is presented
//   on o_data with a 1-cycle o_valid pulse; a low stop bit gives a 1-cycle
//   o_frame_err pulse and the receiver waits in BREAK until the line is high.
//   - clock      : system clock
//   - reset      : synchronous, active-high
//   - bus        : uart_rx_if master (i_serial in; o_data/o_valid/
//                  o_frame_err/o_busy out)
//   Parameter clocks_per_bit (>= 4): clock cycles per serial bit.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 20000
) (
    input  logic       clock,
    input  logic       reset,
    uart_rx_if.master  bus
);

    localparam int TIMER_W = $clog2(clocks_per_bit);
    localparam logic [TIMER_W-1:0] TIMER_FULL = TIMER_W'(clocks_per_bit - 1);
    localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(clocks_per_bit / 2 - 1);
    localparam logic [2:0]         LAST_BIT   = 3'(DATA_BITS - 1);

    uart_rx_state_t       state, next_state;
    logic                 rx, rx_prev;
    logic [TIMER_W-1:0]   timer;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 start_edge, timer_zero;
    logic                 load_data, frame_err_set;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.i_serial),
        .q     (rx)
    );

    // rx_prev resets high, so a line held low out of reset yields one edge.
    always_ff @(posedge clock) begin
        if (reset) rx_prev <= 1'b1;
        else       rx_prev <= rx;
    end

    assign start_edge = rx_prev & ~rx;
    assign timer_zero = (timer == '0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start_edge)                        next_state = START;
            START: if (timer_zero)                        next_state = rx ? IDLE : DATA;
            DATA:  if (timer_zero && bit_idx == LAST_BIT) next_state = STOP;
            STOP:  if (timer_zero)                        next_state = rx ? IDLE : BREAK;
            BREAK: if (rx)                                next_state = IDLE;
            default:                                      next_state = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        load_data     = (state == STOP) && timer_zero &&  rx;
        frame_err_set = (state == STOP) && timer_zero && !rx;
        bus.o_busy    = (state != IDLE);
    end

    // Bit timer, bit index and shift register. IDLE is re-entered at
    // mid-stop-bit so a start edge right after the stop bit is not lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start_edge) timer <= TIMER_HALF;
                START: begin
                    if (timer_zero) begin
                        timer   <= TIMER_FULL;
                        bit_idx <= '0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                DATA: begin
                    if (timer_zero) begin
                        shreg   <= {rx, shreg[DATA_BITS-1:1]};
                        timer   <= TIMER_FULL;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                STOP: if (!timer_zero) timer <= timer - TIMER_W'(1);
                default: ;
            endcase
        end
    end

    // Registered outputs; the two pulses are mutually exclusive by decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.o_data      <= '0;
            bus.o_valid     <= 1'b0;
            bus.o_frame_err <= 1'b0;
        end else begin
            bus.o_valid     <= load_data;
            bus.o_frame_err <= frame_err_set;
            if (load_data) bus.o_data <= shreg;
        end
    end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx with clocks_per_bit = 8. Frames are driven
//   bit-exactly on i_serial; a queue of expected bytes (with the cycle their
//   start bit was driven) is consumed by a monitor on every o_valid pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB     = 8;
    localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic clock;
    logic reset;

    uart_rx_if dut_if ();

    uart_rx #(.clocks_per_bit(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dut_if.master)
    );

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       exp_q[$];
    int         valid_times[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives one 10-bit frame; must be called just after a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit expect_ok);
        logic [9:0] frame;
        exp_t       e;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            dut_if.i_serial = frame[i];
            if (i == 0 && expect_ok) begin
                e.data  = b;
                e.start = cyc;
                exp_q.push_back(e);
            end
            wait_cycles(CPB);
        end
    endtask

    // Monitor: pops the reference queue on each good byte.
    always @(negedge clock) begin
        exp_t e;
        int   lat;
        if (!reset) begin
            if (dut_if.o_valid || dut_if.o_frame_err)
                check("valid_ferr_exclusive", 32'(dut_if.o_valid & dut_if.o_frame_err), 0);
            if (dut_if.o_valid) begin
                valid_cnt++;
                valid_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(dut_if.o_data), 32'(e.data));
                    lat = cyc - e.start;
                    check("latency_in_window", 32'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1);
                    last_good = e.data;
                end
            end
            if (dut_if.o_frame_err) begin
                ferr_cnt++;
                check("ferr_data_held", 32'(dut_if.o_data), 32'(last_good));
            end
        end
    end

    initial begin
        int v0, f0, busy_cycles, n;
        logic [7:0] b;

        reset           = 1'b1;
        dut_if.i_serial = 1'b1;
        wait_cycles(4);
        check("reset_data",  32'(dut_if.o_data), 0);
        check("reset_valid", 32'(dut_if.o_valid), 0);
        check("reset_ferr",  32'(dut_if.o_frame_err), 0);
        check("reset_busy",  32'(dut_if.o_busy), 0);
        reset = 1'b0;
        wait_cycles(CPB);

        // 1. Single clean byte
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h55, 1'b1, 1'b1);
        wait_cycles(4);
        check("t1_valid_count", 32'(valid_cnt - v0), 1);
        check("t1_ferr_count",  32'(ferr_cnt - f0), 0);
        check("t1_data",        32'(dut_if.o_data), 32'h55);

        // 2. Two-cycle glitch, then a clean byte
        v0 = valid_cnt; f0 = ferr_cnt;
        dut_if.i_serial = 1'b0;
        wait_cycles(2);
        dut_if.i_serial = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            wait_cycles(1);
            if (dut_if.o_busy) busy_cycles++;
        end
        check("t2_glitch_busy_short", 32'(busy_cycles <= CPB / 2 + 2), 1);
        check("t2_glitch_valid",      32'(valid_cnt - v0), 0);
        check("t2_glitch_ferr",       32'(ferr_cnt - f0), 0);
        send_byte(8'hA3, 1'b1, 1'b1);
        wait_cycles(4);
        check("t2_valid_count", 32'(valid_cnt - v0), 1);
        check("t2_data",        32'(dut_if.o_data), 32'hA3);

        // 3. Framing error, held-low line, recovery
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'hA5, 1'b0, 1'b0);
        dut_if.i_serial = 1'b0;
        wait_cycles(3 * CPB);
        dut_if.i_serial = 1'b1;
        wait_cycles(2 * CPB);
        check("t3_ferr_count",  32'(ferr_cnt - f0), 1);
        check("t3_no_valid",    32'(valid_cnt - v0), 0);
        check("t3_data_held",   32'(dut_if.o_data), 32'hA3);
        send_byte(8'h3C, 1'b1, 1'b1);
        wait_cycles(4);
        check("t3_valid_count", 32'(valid_cnt - v0), 1);
        check("t3_data",        32'(dut_if.o_data), 32'h3C);

        // 4. Back-to-back frames, no idle gap
        v0 = valid_cnt;
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h81, 1'b1, 1'b1);
        wait_cycles(4);
        check("t4_valid_count", 32'(valid_cnt - v0), 3);
        n = valid_times.size();
        if (n >= 3) begin
            check("t4_spacing_1", 32'(valid_times[n-2] - valid_times[n-3]), 32'(10 * CPB));
            check("t4_spacing_2", 32'(valid_times[n-1] - valid_times[n-2]), 32'(10 * CPB));
        end else begin
            check("t4_pulse_times_recorded", 32'(n), 3);
        end
        check("t4_last_data", 32'(dut_if.o_data), 32'h81);

        // 5. Reset pulse in the middle of bit 4 of 0xF0
        v0 = valid_cnt; f0 = ferr_cnt;
        fork
            send_byte(8'hF0, 1'b1, 1'b0);
            begin
                wait_cycles(5 * CPB + CPB / 2);
                reset     = 1'b1;
                last_good = 8'h00;
                wait_cycles(1);
                check("t5_busy_after_reset", 32'(dut_if.o_busy), 0);
                check("t5_data_after_reset", 32'(dut_if.o_data), 0);
                reset = 1'b0;
            end
        join
        wait_cycles(2 * CPB);
        check("t5_no_valid", 32'(valid_cnt - v0), 0);
        check("t5_no_ferr",  32'(ferr_cnt - f0), 0);
        send_byte(8'h12, 1'b1, 1'b1);
        wait_cycles(4);
        check("t5_valid_count", 32'(valid_cnt - v0), 1);
        check("t5_data",        32'(dut_if.o_data), 32'h12);

        // Random bytes with random idle gaps
        v0 = valid_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 16; i++) begin
            wait_cycles($urandom_range(0, 12));
            b = 8'($urandom);
            send_byte(b, 1'b1, 1'b1);
        end
        wait_cycles(4);
        check("rand_valid_count", 32'(valid_cnt - v0), 16);
        check("rand_no_ferr",     32'(ferr_cnt - f0), 0);

        // 6. Line low through reset release for 20 bit times
        reset           = 1'b1;
        dut_if.i_serial = 1'b0;
        last_good       = 8'h00;
        wait_cycles(3);
        reset = 1'b0;
        v0 = valid_cnt; f0 = ferr_cnt;
        wait_cycles(20 * CPB);
        dut_if.i_serial = 1'b1;
        wait_cycles(2 * CPB);
        check("t6_ferr_at_most_one", 32'(ferr_cnt - f0 <= 1), 1);
        check("t6_no_valid_low",     32'(valid_cnt - v0), 0);
        send_byte(8'h7E, 1'b1, 1'b1);
        wait_cycles(4);
        check("t6_valid_count", 32'(valid_cnt - v0), 1);
        check("t6_data",        32'(dut_if.o_data), 32'h7E);

        check("expected_queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx
